// File: rtl/dht11_result_if.sv
// Result handshake bundle between the DHT11 measurement controller and its consumer.
// The master drives the result word and valid; the slave returns ready.
interface dht11_result_if;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] humidity_int;
  logic [7:0] humidity_dec;
  logic [7:0] temperature_int;
  logic [7:0] temperature_dec;
  logic [1:0] status;

  modport master (
    output result_valid,
    output humidity_int,
    output humidity_dec,
    output temperature_int,
    output temperature_dec,
    output status,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  humidity_int,
    input  humidity_dec,
    input  temperature_int,
    input  temperature_dec,
    input  status,
    output result_ready
  );
endinterface

// File: rtl/dht11_measurement_controller.sv
// Sequences DHT11 decoder reads, validates the frame checksum and presents one result word.
// Optional retry of failed attempts is compiled in with `define DHT11_RETRY_EN.
module dht11_measurement_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned RELEASE_CYCLES = 1000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  measure_request,
  output logic                  sensor_enable,
  input  logic [39:0]           sensor_data,
  input  logic                  sensor_error,
  input  logic                  sensor_done,
  output logic                  busy,
  output logic [7:0]            error_count,
  dht11_result_if.master        result
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > RELEASE_CYCLES) ? TIMEOUT_CYCLES
                                                                      : RELEASE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  typedef enum logic [2:0] {StIdle, StWaitDone, StCheck, StRelease, StPresent} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      done_sync_q, err_sync_q;
  logic [39:0]     frame_q;
  logic            frame_err_q;
  logic            timeout_q;
  logic [1:0]      attempt_status_q;
  logic [1:0]      check_status;
  logic [7:0]      checksum;
  logic [1:0]      status_q;
  logic [31:0]     fields_q;
  logic [7:0]      error_count_q;
  logic            enable_q;
  logic            retry_pending;
  logic            done_seen;
  logic            timeout_hit;
  logic            release_end;

  assign done_seen   = done_sync_q[1];
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign release_end = (cnt_q == CntW'(RELEASE_CYCLES - 1));

`ifdef DHT11_RETRY_EN
  localparam int unsigned AttW = $clog2(MAX_RETRIES + 2);
  logic [AttW-1:0] attempts_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      attempts_q <= '0;
    end else if (state_q == StIdle && state_d == StWaitDone) begin
      attempts_q <= '0;
    end else if (state_q == StCheck) begin
      attempts_q <= attempts_q + 1'b1;
    end
  end

  // attempts_q counts completed attempts, so MAX_RETRIES extra tries follow the first.
  assign retry_pending = (attempt_status_q != 2'b00) && (attempts_q <= AttW'(MAX_RETRIES));
`else
  assign retry_pending = 1'b0;
`endif

  assign checksum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

  always_comb begin
    check_status = 2'b00;
    if (timeout_q) begin
      check_status = 2'b11;
    end else if (frame_err_q) begin
      check_status = 2'b10;
    end else if (checksum != frame_q[7:0]) begin
      check_status = 2'b01;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (measure_request) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (done_seen || timeout_hit) state_d = StCheck;
      end
      StCheck: begin
        state_d = StRelease;
      end
      StRelease: begin
        if (release_end) state_d = retry_pending ? StWaitDone : StPresent;
      end
      StPresent: begin
        if (result.result_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Counter serves both the timeout and the release gap; it restarts on every state change.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q || !(state_q == StWaitDone || state_q == StRelease)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      done_sync_q      <= '0;
      err_sync_q       <= '0;
      frame_q          <= '0;
      frame_err_q      <= 1'b0;
      timeout_q        <= 1'b0;
      attempt_status_q <= 2'b00;
      status_q         <= 2'b00;
      fields_q         <= '0;
      error_count_q    <= '0;
      enable_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_sync_q <= {done_sync_q[0], sensor_done};
      err_sync_q  <= {err_sync_q[0], sensor_error};
      enable_q    <= (state_d == StWaitDone);

      if (state_q == StWaitDone) begin
        if (done_seen) begin
          frame_q     <= sensor_data;
          frame_err_q <= err_sync_q[1];
          timeout_q   <= 1'b0;
        end else if (timeout_hit) begin
          timeout_q   <= 1'b1;
        end
      end

      if (state_q == StCheck) begin
        attempt_status_q <= check_status;
        if (check_status != 2'b00 && error_count_q != 8'hff) begin
          error_count_q <= error_count_q + 8'd1;
        end
      end

      // On a timeout the previous result bytes are kept.
      if (state_q == StRelease && state_d == StPresent) begin
        status_q <= attempt_status_q;
        if (attempt_status_q != 2'b11) fields_q <= frame_q[39:8];
      end
    end
  end

  assign sensor_enable          = enable_q;
  assign busy                   = (state_q != StIdle);
  assign error_count            = error_count_q;
  assign result.result_valid    = (state_q == StPresent);
  assign result.status          = status_q;
  assign result.humidity_int    = fields_q[31:24];
  assign result.humidity_dec    = fields_q[23:16];
  assign result.temperature_int = fields_q[15:8];
  assign result.temperature_dec = fields_q[7:0];

endmodule

// File: tb/tb_dht11_measurement_controller.sv
// Directed table-driven bench for dht11_measurement_controller with a simple decoder model.
// Expected error counts and pulse counts scale with retries when DHT11_RETRY_EN is defined.
module tb_dht11_measurement_controller;

  localparam int unsigned TO  = 100;
  localparam int unsigned REL = 20;
  localparam int unsigned MR  = 3;
`ifdef DHT11_RETRY_EN
  localparam int ATT = MR + 1;
`else
  localparam int ATT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        measure_request;
  logic        sensor_enable;
  logic [39:0] sensor_data;
  logic        sensor_error;
  logic        sensor_done;
  logic        busy;
  logic [7:0]  error_count;

  dht11_result_if res_if ();

  dht11_measurement_controller #(
    .TIMEOUT_CYCLES (TO),
    .RELEASE_CYCLES (REL),
    .MAX_RETRIES    (MR)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .measure_request (measure_request),
    .sensor_enable   (sensor_enable),
    .sensor_data     (sensor_data),
    .sensor_error    (sensor_error),
    .sensor_done     (sensor_done),
    .busy            (busy),
    .error_count     (error_count),
    .result          (res_if.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [39:0] frame;
    logic        err;
    logic        respond;
    logic [1:0]  st;
    logic [31:0] fields;
    int          fail;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decoder model: answers a fixed number of cycles after enable, holds done until enable drops.
  logic [39:0] model_frame;
  logic        model_err;
  logic        model_respond;
  int          resp_cnt;

  always @(negedge clock) begin
    if (!sensor_enable) begin
      sensor_done = 1'b0;
      resp_cnt    = 0;
    end else if (model_respond) begin
      resp_cnt++;
      if (resp_cnt == 5) begin
        sensor_data  = model_frame;
        sensor_error = model_err;
        sensor_done  = 1'b1;
      end
    end
  end

  int   cyc = 0, pulses = 0, hi_len = 0, last_hi = 0, lo_len = 0, min_gap = 1 << 30;
  int   t_done = 0, t_valid = 0;
  logic prev_en = 1'b0, prev_done = 1'b0, prev_valid = 1'b0;

  always @(negedge clock) begin
    #1;
    cyc++;
    if (sensor_enable) begin
      if (!prev_en) begin
        pulses++;
        if (pulses > 1 && lo_len < min_gap) min_gap = lo_len;
        hi_len = 0;
      end
      hi_len++;
    end else begin
      if (prev_en) begin
        last_hi = hi_len;
        lo_len  = 0;
      end
      lo_len++;
    end
    if (sensor_done && !prev_done) t_done = cyc;
    if (res_if.result_valid && !prev_valid) t_valid = cyc;
    prev_en    = sensor_enable;
    prev_done  = sensor_done;
    prev_valid = res_if.result_valid;
  end

  function automatic logic [31:0] fields_now();
    return {res_if.humidity_int, res_if.humidity_dec,
            res_if.temperature_int, res_if.temperature_dec};
  endfunction

  task automatic do_request();
    @(negedge clock);
    measure_request = 1'b1;
    @(negedge clock);
    measure_request = 1'b0;
    check("req_enable", {39'd0, sensor_enable}, 40'd1);
    check("req_busy", {39'd0, busy}, 40'd1);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (res_if.result_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got no result_valid expected result_valid within 3000 cycles");
    end
  endtask

  task automatic handshake();
    @(negedge clock);
    res_if.result_ready = 1'b1;
    @(negedge clock);
    res_if.result_ready = 1'b0;
    check("hs_valid_low", {39'd0, res_if.result_valid}, 40'd0);
    check("hs_busy_low", {39'd0, busy}, 40'd0);
  endtask

  task automatic run_vec(input vec_t v, input int exp_cnt, input bit chk_latency);
    int p0;
    bit ok;
    model_frame   = v.frame;
    model_err     = v.err;
    model_respond = v.respond;
    p0 = pulses;
    do_request();
    wait_valid(ok);
    if (ok) begin
      check("status", {38'd0, res_if.status}, {38'd0, v.st});
      check("fields", {8'd0, fields_now()}, {8'd0, v.fields});
      check("error_count", {32'd0, error_count}, 40'(exp_cnt));
      check("enable_pulses", 40'(pulses - p0), 40'((v.fail != 0) ? ATT : 1));
      if (!v.respond) check("timeout_enable_len", 40'(last_hi), 40'(TO));
      handshake();
      // done set -> 2 sync cycles + CHECK + RELEASE + 1 until valid
      if (chk_latency) check("valid_latency", 40'(t_valid - t_done), 40'(REL + 4));
    end
  endtask

  initial begin
    int       exp_cnt;
    int       p0;
    bit       ok;
    bit       stable;
    logic [33:0] snap;

    vecs[0] = '{40'h37001A0051, 1'b0, 1'b1, 2'b00, 32'h37001A00, 0};
    vecs[1] = '{40'h37001A0052, 1'b0, 1'b1, 2'b01, 32'h37001A00, 1};
    vecs[2] = '{40'h4105190564, 1'b0, 1'b1, 2'b00, 32'h41051905, 0};
    vecs[3] = '{40'h2000150035, 1'b1, 1'b1, 2'b10, 32'h20001500, 1};
    vecs[4] = '{40'h0000000000, 1'b0, 1'b0, 2'b11, 32'h20001500, 1};
    vecs[5] = '{40'hFF807F0200, 1'b0, 1'b1, 2'b00, 32'hFF807F02, 0};
    vecs[6] = '{40'h0102030400, 1'b1, 1'b1, 2'b10, 32'h01020304, 1};

    reset               = 1'b1;
    measure_request     = 1'b0;
    sensor_data         = '0;
    sensor_error        = 1'b0;
    sensor_done         = 1'b0;
    res_if.result_ready = 1'b0;
    model_frame         = '0;
    model_err           = 1'b0;
    model_respond       = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_enable", {39'd0, sensor_enable}, 40'd0);
    check("rst_busy", {39'd0, busy}, 40'd0);
    check("rst_valid", {39'd0, res_if.result_valid}, 40'd0);
    check("rst_status", {38'd0, res_if.status}, 40'd0);
    check("rst_fields", {8'd0, fields_now()}, 40'd0);
    check("rst_error_count", {32'd0, error_count}, 40'd0);
    reset = 1'b0;

    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      exp_cnt += vecs[i].fail * ATT;
      if (exp_cnt > 255) exp_cnt = 255;
      run_vec(vecs[i], exp_cnt, i == 0);
      repeat (2) @(negedge clock);
    end

    // Backpressure with a request pulsed during PRESENT and on the handshake cycle.
    model_frame   = 40'h4105190564;
    model_err     = 1'b0;
    model_respond = 1'b1;
    do_request();
    wait_valid(ok);
    if (ok) begin
      snap   = {fields_now(), res_if.status};
      p0     = pulses;
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clock);
        measure_request = (i == 10);
        if ({fields_now(), res_if.status} !== snap || !res_if.result_valid) stable = 1'b0;
      end
      measure_request = 1'b0;
      check("bp_stable", {39'd0, stable}, 40'd1);
      check("bp_no_pulse", 40'(pulses - p0), 40'd0);
      @(negedge clock);
      res_if.result_ready = 1'b1;
      measure_request     = 1'b1;
      @(negedge clock);
      res_if.result_ready = 1'b0;
      measure_request     = 1'b0;
      check("bp_valid_low", {39'd0, res_if.result_valid}, 40'd0);
      check("bp_busy_low", {39'd0, busy}, 40'd0);
      repeat (5) @(negedge clock);
      check("bp_not_queued_busy", {39'd0, busy}, 40'd0);
      check("bp_not_queued_pulse", 40'(pulses - p0), 40'd0);
    end

    // Reset in WAIT_DONE, then a normal read.
    model_respond = 1'b0;
    do_request();
    repeat (10) @(negedge clock);
    check("mid_enable_high", {39'd0, sensor_enable}, 40'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_enable", {39'd0, sensor_enable}, 40'd0);
    check("mid_rst_busy", {39'd0, busy}, 40'd0);
    check("mid_rst_error_count", {32'd0, error_count}, 40'd0);
    check("mid_rst_valid", {39'd0, res_if.result_valid}, 40'd0);
    reset = 1'b0;
    repeat (REL + 5) @(negedge clock);
    run_vec(vecs[0], 0, 1'b0);

    check("min_low_gap_ok", {39'd0, min_gap >= REL}, 40'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
